// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Conditions the raw, asynchronous, active-low user button. The pin is
// synchronised, debounced, and turned into a clean pressed level plus
// single-cycle event pulses (press, release, short click, long press and,
// optionally, auto-repeat). Downstream logic uses these outputs in place of
// the raw pin.
//
// Optional feature macro: BTN_REPEAT_EN
//   defined   : btn_repeat pulses every REPEAT_CYCLES while the button stays
//               held after a long press.
//   undefined : btn_repeat is tied to 0 and no repeat counter is built.
//
// Ports
//   clk_16mhz   in   system clock, 16 MHz
//   rst_n       in   synchronous active-low reset
//   btn_usr     in   raw button pin, asynchronous, 0 = pressed
//   btn_level   out  debounced level, 1 = pressed
//   btn_press   out  one-cycle pulse on debounced press
//   btn_release out  one-cycle pulse on debounced release
//   btn_short   out  one-cycle pulse on release before the long threshold
//   btn_long    out  one-cycle pulse when the hold reaches LONG_PRESS_CYCLES
//   btn_repeat  out  one-cycle auto-repeat pulse (0 without BTN_REPEAT_EN)
//
// Timing
//   The first clock edge that samples a stable new btn_usr value is cycle 0.
//   The internal debounced level flips at edge 1 + DEBOUNCE_CYCLES; all
//   outputs are registered, so btn_level and any pulse tied to that change
//   appear together at edge 2 + DEBOUNCE_CYCLES and pulses last one cycle.
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES   = 160000,
  parameter int LONG_PRESS_CYCLES = 16000000,
  parameter int REPEAT_CYCLES     = 4000000
) (
  input  logic clk_16mhz,
  input  logic rst_n,
  input  logic btn_usr,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_short,
  output logic btn_long,
  output logic btn_repeat
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
    $error("btn_debounce: LONG_PRESS_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("btn_debounce: REPEAT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. Flops reset to 1 (button released) so a button
  // held through reset is seen as a fresh press that must be debounced.
  // ---------------------------------------------------------------------------
  logic sync_0;
  logic sync_1;
  logic s;

  always_ff @(posedge clk_16mhz) begin
    if (!rst_n) begin
      sync_0 <= 1'b1;
      sync_1 <= 1'b1;
    end else begin
      sync_0 <= btn_usr;
      sync_1 <= sync_0;
    end
  end

  // Active-high pressed sample.
  assign s = ~sync_1;

  // ---------------------------------------------------------------------------
  // Debounce counter. Counts consecutive cycles where the synchronised sample
  // disagrees with the debounced level; any agreeing cycle (a bounce) restarts
  // the count from zero.
  // ---------------------------------------------------------------------------
  logic            deb;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk_16mhz) begin
    if (!rst_n) begin
      deb    <= 1'b0;
      db_cnt <= '0;
    end else if (s != deb) begin
      if (db_cnt == DB_LAST) begin
        deb    <= ~deb;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // btn_level is the registered copy of deb, so a difference between the two
  // marks the single cycle in which the debounced level has just changed.
  logic rise;
  logic fall;

  assign rise = deb & ~btn_level;
  assign fall = ~deb & btn_level;

  // ---------------------------------------------------------------------------
  // Press classification FSM.
  // ---------------------------------------------------------------------------
  state_t              state;
  state_t              state_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_nxt;
  logic                press_nxt;
  logic                release_nxt;
  logic                short_nxt;
  logic                long_nxt;
  logic                repeat_nxt;

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    short_nxt   = 1'b0;
    long_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = HELD;
          hold_nxt  = '0;
          press_nxt = 1'b1;
        end
      end

      HELD: begin
        // The hold count tops out at LONG_PRESS_CYCLES, which the counter
        // width holds, because HELD is always left on the threshold cycle.
        hold_nxt = hold_cnt + 1'b1;
        // Release wins over the long threshold when both land on one cycle.
        if (fall) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          short_nxt   = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
        end
      end

      LONG_HELD: begin
        if (fall) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef BTN_REPEAT_EN
  // ---------------------------------------------------------------------------
  // Auto-repeat counter. Held at zero outside LONG_HELD, so it is already
  // clear on entry and no repeat can coincide with the btn_long cycle. A
  // release on a repeat boundary suppresses that final repeat.
  // ---------------------------------------------------------------------------
  localparam int                REP_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_nxt;

  always_comb begin
    rep_nxt    = '0;
    repeat_nxt = 1'b0;
    if (state == LONG_HELD && !fall) begin
      if (rep_cnt == REP_LAST) begin
        repeat_nxt = 1'b1;
        rep_nxt    = '0;
      end else begin
        rep_nxt = rep_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_16mhz) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_nxt;
    end
  end
`else
  assign repeat_nxt = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_16mhz) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_short   <= 1'b0;
      btn_long    <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      btn_level   <= deb;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      btn_short   <= short_nxt;
      btn_long    <= long_nxt;
      btn_repeat  <= repeat_nxt;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
//
// Self-checking bench for btn_debounce with DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20, REPEAT_CYCLES=8. Each test segment is a per-cycle
// stimulus array plus an expected output timeline derived from the documented
// timing: a clean low pulse of length H starting at sampling edge t0 gives
// btn_press at t0+6, btn_release at t0+H+6, short when H <= 20, otherwise
// btn_long at press+20 and (with BTN_REPEAT_EN) repeats every 8 cycles after
// that while still held.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_btn_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;
  localparam int MAXN = 256;
  localparam int LAT  = DEB + 2;

  // Bit positions in the packed output vector.
  localparam int B_LVL = 5;
  localparam int B_PRS = 4;
  localparam int B_REL = 3;
  localparam int B_SHT = 2;
  localparam int B_LNG = 1;
  localparam int B_REP = 0;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic clk_16mhz = 1'b0;
  logic rst_n;
  logic btn_usr;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_short;
  logic btn_long;
  logic btn_repeat;

  always #31 clk_16mhz = ~clk_16mhz;

  btn_debounce #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG),
    .REPEAT_CYCLES    (REP)
  ) dut (
    .clk_16mhz  (clk_16mhz),
    .rst_n      (rst_n),
    .btn_usr    (btn_usr),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_short  (btn_short),
    .btn_long   (btn_long),
    .btn_repeat (btn_repeat)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [5:0] exp_q[$];
  int         tests   = 0;
  int         fails   = 0;
  int         printed = 0;

  logic       stim_btn[MAXN];
  logic       stim_rst[MAXN];
  logic [5:0] exp_tl[MAXN];
  int         seg_n;

  int cnt_press, cnt_rel, cnt_short, cnt_long, cnt_rep;

  typedef struct {
    int idle;
    int hold;
    int tail;
    int e_press;
    int e_rel;
    int e_short;
    int e_long;
    int e_rep;   // repeats expected when BTN_REPEAT_EN is defined
  } row_t;

  row_t rows[7];

  // ---------------------------------------------------------------------------
  // Driver / scoreboard tasks
  // ---------------------------------------------------------------------------
  task automatic clear_seg(input int n);
    seg_n = n;
    for (int i = 0; i < MAXN; i++) begin
      stim_btn[i] = 1'b1;
      stim_rst[i] = 1'b1;
      exp_tl[i]   = '0;
    end
  endtask

  // Clean low pulse on btn_usr from sampling edge t0 for hold cycles, starting
  // from an idle, settled DUT. Fills stimulus and expected timeline.
  task automatic add_press(input int t0, input int hold);
    int p;
    int rl;
    for (int k = t0; k < t0 + hold; k++) stim_btn[k] = 1'b0;
    if (hold >= DEB) begin
      p  = t0 + LAT;
      rl = t0 + hold + LAT;
      for (int k = p; k < rl && k < seg_n; k++) exp_tl[k][B_LVL] = 1'b1;
      exp_tl[p][B_PRS] = 1'b1;
      if (rl < seg_n) begin
        exp_tl[rl][B_REL] = 1'b1;
        if (hold <= LONG) exp_tl[rl][B_SHT] = 1'b1;
      end
      if (hold > LONG) begin
        exp_tl[p + LONG][B_LNG] = 1'b1;
`ifdef BTN_REPEAT_EN
        for (int r = p + LONG + REP; r < rl; r += REP) exp_tl[r][B_REP] = 1'b1;
`endif
      end
    end
  endtask

  task automatic check_cycle(input string name, input int k);
    logic [5:0] act;
    logic [5:0] exp;
    act = {btn_level, btn_press, btn_release, btn_short, btn_long, btn_repeat};
    exp = exp_q.pop_front();
    tests++;
    if (act !== exp) begin
      fails++;
      if (printed < 60) begin
        printed++;
        $display("FAIL %s cycle %0d: got lvl/prs/rel/sht/lng/rep=%b expected %b",
                 name, k, act, exp);
      end
    end
    if (btn_press)   cnt_press++;
    if (btn_release) cnt_rel++;
    if (btn_short)   cnt_short++;
    if (btn_long)    cnt_long++;
    if (btn_repeat)  cnt_rep++;
  endtask

  // Push the whole expected timeline, then drive each cycle and compare the
  // registered outputs 1 ns after the edge that produced them.
  task automatic run_seg(input string name);
    cnt_press = 0; cnt_rel = 0; cnt_short = 0; cnt_long = 0; cnt_rep = 0;
    for (int k = 0; k < seg_n; k++) exp_q.push_back(exp_tl[k]);
    for (int k = 0; k < seg_n; k++) begin
      btn_usr = stim_btn[k];
      rst_n   = stim_rst[k];
      @(posedge clk_16mhz);
      #1;
      check_cycle(name, k);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_counts(input string name, input int ep, input int er,
                              input int es, input int el, input int erp);
    check_int({name, " press count"},   cnt_press, ep);
    check_int({name, " release count"}, cnt_rel,   er);
    check_int({name, " short count"},   cnt_short, es);
    check_int({name, " long count"},    cnt_long,  el);
    check_int({name, " repeat count"},  cnt_rep,   erp);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int h;
    int i0;
    int erp;

    rst_n   = 1'b0;
    btn_usr = 1'b1;

    //        idle hold tail prs rel sht lng rep
    rows[0] = '{3,  10,  8,   1,  1,  1,  0,  0};  // short click
    rows[1] = '{3,  40,  8,   1,  1,  0,  1,  2};  // long press
    rows[2] = '{2,  20,  8,   1,  1,  1,  0,  0};  // release on hold count 19
    rows[3] = '{2,  21,  8,   1,  1,  0,  1,  0};  // one past the threshold
    rows[4] = '{4,   3,  8,   0,  0,  0,  0,  0};  // glitch shorter than debounce
    rows[5] = '{1,   4,  8,   1,  1,  1,  0,  0};  // shortest accepted press
    rows[6] = '{3,  80,  8,   1,  1,  0,  1,  7};  // 60 cycles past btn_long

    // Reset state: all outputs 0 while rst_n is low.
    clear_seg(4);
    for (int k = 0; k < 4; k++) stim_rst[k] = 1'b0;
    run_seg("reset");

    // Table-driven press/hold/release vectors.
    for (int r = 0; r < 7; r++) begin
      clear_seg(rows[r].idle + rows[r].hold + rows[r].tail);
      add_press(rows[r].idle, rows[r].hold);
      run_seg($sformatf("row%0d", r));
`ifdef BTN_REPEAT_EN
      erp = rows[r].e_rep;
`else
      erp = 0;
`endif
      check_counts($sformatf("row%0d", r), rows[r].e_press, rows[r].e_rel,
                   rows[r].e_short, rows[r].e_long, erp);
    end

    // Bounce: toggle every 2 cycles for 20 cycles, then stay released.
    clear_seg(32);
    for (int k = 0; k < 20; k++) stim_btn[k] = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
    run_seg("bounce");
    check_counts("bounce", 0, 0, 0, 0, 0);

    // Reset for one cycle during HELD with the button still held. Press at 8,
    // reset edge 18, first post-reset sampling edge 19, re-press at 25,
    // release sampled from edge 30 lands at 36 as a short click.
    clear_seg(46);
    for (int k = 2; k < 30; k++) stim_btn[k] = 1'b0;
    stim_rst[18] = 1'b0;
    for (int k = 8; k < 18; k++) exp_tl[k][B_LVL] = 1'b1;
    exp_tl[8][B_PRS] = 1'b1;
    for (int k = 25; k < 36; k++) exp_tl[k][B_LVL] = 1'b1;
    exp_tl[25][B_PRS] = 1'b1;
    exp_tl[36][B_REL] = 1'b1;
    exp_tl[36][B_SHT] = 1'b1;
    run_seg("mid_reset");
    check_counts("mid_reset", 2, 1, 1, 0, 0);

    // Randomised hold lengths, avoiding a release that lands on a repeat slot.
    for (int n = 0; n < 6; n++) begin
      h  = $urandom_range(4, 50);
      i0 = $urandom_range(1, 5);
      if (h > LONG && ((h - LONG) % REP) == 0) h = h + 1;
      clear_seg(i0 + h + 8);
      add_press(i0, h);
      run_seg($sformatf("rand%0d_h%0d", n, h));
`ifdef BTN_REPEAT_EN
      erp = (h > LONG) ? (h - LONG - 1) / REP : 0;
`else
      erp = 0;
`endif
      check_counts($sformatf("rand%0d_h%0d", n, h), 1, 1,
                   (h <= LONG) ? 1 : 0, (h > LONG) ? 1 : 0, erp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
